// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response bus between a load/store unit and dmem_ctrl.
// Rev 1.0
`default_nettype none

interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, req_we, req_type, addr, wdata, pc,
    input  req_ready, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, req_we, req_type, addr, wdata, pc,
    output req_ready, rsp_valid, rdata, err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data memory with RISC-V b/h/w load/store handling.
// Rev 1.0
`default_nettype none

module dmem_ctrl #(
  parameter int DEPTH    = 128,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  dmem_ctrl_if.slave  bus
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(READ_LAT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      cnt;
  logic [2:0]      cnt_nxt;

  logic [31:0]     mem [DEPTH];

  logic            ready;
  logic            accept;
  logic            legal;
  logic            store_commit;
  logic [AW-1:0]   idx;
  logic [1:0]      ofs;
  logic [31:0]     cur_word;
  logic [31:0]     shifted;
  logic [15:0]     half;
  logic [31:0]     load_data;
  logic [31:0]     wlanes;
  logic [3:0]      be;
  logic [31:0]     merged;
  logic [31:0]     pend_data;

  logic            rsp_set;
  logic            rsp_err;
  logic [31:0]     rsp_data;
  logic            rsp_valid_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  assign ready        = (state == IDLE);
  assign accept       = bus.req_valid && ready && rstn;
  assign idx          = bus.addr[AW+1:2];
  assign ofs          = bus.addr[1:0];
  assign cur_word     = mem[idx];
  assign store_commit = accept && legal && bus.req_we;

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

  // Illegal funct3 codes share the misaligned path.
  always_comb begin
    legal = 1'b0;
    case (bus.req_type)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~ofs[0];
      3'b010:         legal = (ofs == 2'b00);
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    be     = 4'b1111;
    wlanes = bus.wdata;
    case (bus.req_type[1:0])
      2'b00: begin
        be     = 4'b0001 << ofs;
        wlanes = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be     = ofs[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{bus.wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = bus.wdata;
      end
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign merged[8*g +: 8] = be[g] ? wlanes[8*g +: 8] : cur_word[8*g +: 8];
  end

  assign shifted = cur_word >> {ofs, 3'b000};
  assign half    = ofs[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    load_data = cur_word;
    case (bus.req_type)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{half[15]}}, half};
      3'b101:  load_data = {16'h0, half};
      default: load_data = cur_word;
    endcase
  end

  // Memory and the pending load word carry no reset so contents survive rstn.
  always_ff @(posedge clk) begin
    if (store_commit) begin
      mem[idx] <= merged;
    end
    if (accept && !bus.req_we) begin
      pend_data <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rsp_set   = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal) begin
            rsp_set = 1'b1;
            rsp_err = 1'b1;
          end else if (bus.req_we) begin
            rsp_set = 1'b1;
          end else if (READ_LAT == 1) begin
            rsp_set  = 1'b1;
            rsp_data = load_data;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nxt = IDLE;
          rsp_set   = 1'b1;
          rsp_data  = pend_data;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // rdata/err only move on a response so they hold between strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      rsp_valid_q <= rsp_set;
      if (rsp_set) begin
        err_q   <= rsp_err;
        rdata_q <= rsp_data;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (store_commit) begin
      $display("pc = %h: dataaddr = %h, memdata = %h",
               bus.pc, {bus.addr[31:2], 2'b00}, merged);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vector table plus latency/reset sequences for dmem_ctrl.
// Rev 1.0
`default_nettype none

module tb_dmem_ctrl;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if b1 ();
  dmem_ctrl_if b3 ();
  dmem_ctrl_if b4 ();

  dmem_ctrl #(.DEPTH(128), .READ_LAT(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));
  dmem_ctrl #(.DEPTH(128), .READ_LAT(3)) dut3 (.clk(clk), .rstn(rstn), .bus(b3));
  dmem_ctrl #(.DEPTH(128), .READ_LAT(4)) dut4 (.clk(clk), .rstn(rstn), .bus(b4));

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic        we;
    logic [2:0]  t;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    b1.req_valid = 1'b1; b1.req_we = we; b1.req_type = t; b1.addr = a; b1.wdata = d;
    b1.pc = 32'h0000_1000 + a;
  endtask

  task automatic drv3(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    b3.req_valid = 1'b1; b3.req_we = we; b3.req_type = t; b3.addr = a; b3.wdata = d;
    b3.pc = 32'h0000_3000 + a;
  endtask

  task automatic drv4(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    b4.req_valid = 1'b1; b4.req_we = we; b4.req_type = t; b4.addr = a; b4.wdata = d;
    b4.pc = 32'h0000_4000 + a;
  endtask

  initial begin
    int n;

    //             we    type    addr          wdata         err   rdata
    vecs[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h8000_00FF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'h8000_00FF};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FF80};
    vecs[3]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_0080};
    vecs[4]  = '{1'b1, 3'b010, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b1, 3'b001, 32'h0000_0022, 32'h0000_BEEF, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         1'b0, 32'hBEEF_1111};
    vecs[7]  = '{1'b0, 3'b001, 32'h0000_0022, 32'h0,         1'b0, 32'hFFFF_BEEF};
    vecs[8]  = '{1'b0, 3'b101, 32'h0000_0022, 32'h0,         1'b0, 32'h0000_BEEF};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0021, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         1'b0, 32'hBEEF_1111};
    vecs[11] = '{1'b0, 3'b011, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_0000};
    vecs[12] = '{1'b1, 3'b000, 32'h0000_0021, 32'h0000_00AA, 1'b0, 32'h0000_0000};
    vecs[13] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         1'b0, 32'hBEEF_AA11};
    vecs[14] = '{1'b0, 3'b001, 32'h0000_0021, 32'h0,         1'b1, 32'h0000_0000};
    vecs[15] = '{1'b1, 3'b010, 32'h0000_0204, 32'h1234_5678, 1'b0, 32'h0000_0000};
    vecs[16] = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,         1'b0, 32'h1234_5678};
    vecs[17] = '{1'b0, 3'b000, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_0000};
    vecs[18] = '{1'b0, 3'b101, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_00FF};
    vecs[19] = '{1'b0, 3'b001, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_00FF};
    vecs[20] = '{1'b1, 3'b010, 32'h0000_01FC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vecs[21] = '{1'b0, 3'b111, 32'h0000_01FC, 32'h0,         1'b1, 32'h0000_0000};
    vecs[22] = '{1'b1, 3'b110, 32'h0000_01FC, 32'h5555_5555, 1'b1, 32'h0000_0000};
    vecs[23] = '{1'b0, 3'b100, 32'h0000_01FE, 32'h0,         1'b0, 32'h0000_00FE};
    vecs[24] = '{1'b0, 3'b010, 32'h8000_01FC, 32'h0,         1'b0, 32'hCAFE_F00D};

    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_type = 3'b0; b1.addr = '0; b1.wdata = '0; b1.pc = '0;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_type = 3'b0; b3.addr = '0; b3.wdata = '0; b3.pc = '0;
    b4.req_valid = 1'b0; b4.req_we = 1'b0; b4.req_type = 3'b0; b4.addr = '0; b4.wdata = '0; b4.pc = '0;

    rstn = 1'b0;
    step();
    step();
    chk("rst ready",     32'(b1.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("rst rdata",     b1.rdata,          32'h0);
    chk("rst err",       32'(b1.err),       32'd0);
    chk("rst ready3",    32'(b3.req_ready), 32'd1);
    chk("rst rsp4",      32'(b4.rsp_valid), 32'd0);
    rstn = 1'b1;
    step();

    // READ_LAT=1: back-to-back requests, one per cycle.
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("vec%0d ready", i), 32'(b1.req_ready), 32'd1);
      drv1(vecs[i].we, vecs[i].t, vecs[i].addr, vecs[i].wdata);
      step();
      chk($sformatf("vec%0d rsp_valid", i), 32'(b1.rsp_valid), 32'd1);
      chk($sformatf("vec%0d err", i),       32'(b1.err),       32'(vecs[i].eerr));
      chk($sformatf("vec%0d rdata", i),     b1.rdata,          vecs[i].erd);
    end
    b1.req_valid = 1'b0;
    step();
    chk("idle rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("idle rdata hold", b1.rdata, 32'hCAFE_F00D);
    step();
    chk("idle rsp_valid 2", 32'(b1.rsp_valid), 32'd0);

    // READ_LAT=3 handshake with a second request held on the bus.
    drv3(1'b1, 3'b010, 32'h0000_0040, 32'h0000_0080);
    step();
    chk("l3 st rsp",   32'(b3.rsp_valid), 32'd1);
    chk("l3 st err",   32'(b3.err),       32'd0);
    chk("l3 st ready", 32'(b3.req_ready), 32'd1);
    drv3(1'b0, 3'b000, 32'h0000_0040, 32'h0);
    step();
    chk("l3 e0 ready", 32'(b3.req_ready), 32'd0);
    chk("l3 e0 rsp",   32'(b3.rsp_valid), 32'd0);
    drv3(1'b0, 3'b101, 32'h0000_0040, 32'h0);
    step();
    chk("l3 e1 ready", 32'(b3.req_ready), 32'd0);
    chk("l3 e1 rsp",   32'(b3.rsp_valid), 32'd0);
    step();
    chk("l3 e2 ready", 32'(b3.req_ready), 32'd1);
    chk("l3 e2 rsp",   32'(b3.rsp_valid), 32'd1);
    chk("l3 e2 rdata", b3.rdata,          32'hFFFF_FF80);
    chk("l3 e2 err",   32'(b3.err),       32'd0);
    step();
    b3.req_valid = 1'b0;
    chk("l3 2nd acc rsp",   32'(b3.rsp_valid), 32'd0);
    chk("l3 2nd acc ready", 32'(b3.req_ready), 32'd0);
    step();
    chk("l3 2nd wait rsp", 32'(b3.rsp_valid), 32'd0);
    step();
    chk("l3 2nd rsp",   32'(b3.rsp_valid), 32'd1);
    chk("l3 2nd rdata", b3.rdata,          32'h0000_0080);
    step();
    chk("l3 2nd drop", 32'(b3.rsp_valid), 32'd0);
    drv3(1'b0, 3'b010, 32'h0000_0042, 32'h0);
    step();
    b3.req_valid = 1'b0;
    chk("l3 mis rsp",   32'(b3.rsp_valid), 32'd1);
    chk("l3 mis err",   32'(b3.err),       32'd1);
    chk("l3 mis ready", 32'(b3.req_ready), 32'd1);

    // READ_LAT=4: reset pulsed mid-load.
    drv4(1'b1, 3'b010, 32'h0000_0050, 32'hA5A5_5A5A);
    step();
    chk("l4 st rsp", 32'(b4.rsp_valid), 32'd1);
    drv4(1'b0, 3'b010, 32'h0000_0050, 32'h0);
    step();
    b4.req_valid = 1'b0;
    chk("l4 busy ready", 32'(b4.req_ready), 32'd0);
    step();
    rstn = 1'b0;
    #1;
    chk("l4 rst ready", 32'(b4.req_ready), 32'd1);
    chk("l4 rst rsp",   32'(b4.rsp_valid), 32'd0);
    step();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("l4 post rst rsp c%0d", k),   32'(b4.rsp_valid), 32'd0);
      chk($sformatf("l4 post rst ready c%0d", k), 32'(b4.req_ready), 32'd1);
    end
    drv4(1'b0, 3'b010, 32'h0000_0050, 32'h0);
    step();
    b4.req_valid = 1'b0;
    n = 1;
    while (!b4.rsp_valid && n < 10) begin
      step();
      n++;
    end
    chk("l4 latency", 32'(n), 32'd4);
    chk("l4 mem kept", b4.rdata, 32'hA5A5_5A5A);

    drv1(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    step();
    b1.req_valid = 1'b0;
    chk("l1 mem kept rsp", 32'(b1.rsp_valid), 32'd1);
    chk("l1 mem kept",     b1.rdata,          32'h8000_00FF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 128: memory depth in 32-bit words; power of two, 16..4096.
REQ-002 Parameter READ_LAT, default 1: load latency in cycles, legal range 1..4.
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port rstn  in  1  asynchronous active-low reset.
REQ-005 Port req_valid  in  1  access request present.
REQ-006 Port req_ready  out  1  controller can accept a request this cycle.
REQ-007 Port req_we  in  1  1 = store, 0 = load.
REQ-008 Port req_type  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu; other codes are illegal.
REQ-009 Port addr  in  32  byte address.
REQ-010 Port wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port pc  in  32  PC of the requesting instruction, used only for the store trace.
REQ-012 Port rsp_valid  out  1  one-cycle response strobe.
REQ-013 Port rdata  out  32  load result after extension; 0 for stores and errors.
REQ-014 Port err  out  1  valid only with rsp_valid; 1 = misaligned access or illegal type.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-016 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-017 Misalignment SHALL be defined as follows; an illegal req_type SHALL be treated the same way:
- h/hu with addr[0]=1;
- w with addr[1:0]!=0;
- b/bu never misaligned.
REQ-018 A misaligned or illegal request SHALL leave memory unchanged and SHALL produce rsp_valid=1, err=1, rdata=0 in the cycle after acceptance, for both loads and stores.
REQ-019 A legal store SHALL write only the addressed bytes on the accepting edge:
- sb: lane addr[1:0];
- sh: lanes {addr[1],0} and {addr[1],1};
- sw: all four lanes.
REQ-020 A legal store SHALL produce rsp_valid=1, err=0, rdata=0 in the cycle after acceptance, independent of READ_LAT.
REQ-021 Each committed store SHALL emit the simulation-only message "pc = <pc>: dataaddr = <addr with [1:0]=00>, memdata = <merged word>" in hex.
REQ-022 A legal load SHALL sample the addressed word on the accepting edge, select the byte/half by addr[1:0], and apply extension:
- sign-extend for b/h;
- zero-extend for bu/hu.
REQ-023 A legal load SHALL assert rsp_valid=1, err=0 with the extended data exactly READ_LAT cycles after the accepting edge (READ_LAT=1: the next cycle).
REQ-024 The state machine SHALL have two states, IDLE and BUSY:
- IDLE: req_ready=1.
- IDLE to BUSY: legal load accepted with READ_LAT>1; counter loaded with READ_LAT-1.
- BUSY: req_ready=0; counter decrements each cycle.
- BUSY to IDLE: on the edge where the counter reaches 0.
- The response appears in the first IDLE cycle.
REQ-025 A new request SHALL be acceptable in the same cycle rsp_valid is high, giving back-to-back stores and READ_LAT=1 loads one access per cycle.
REQ-026 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-027 rsp_valid SHALL be high for exactly one cycle per accepted request, and never otherwise.
REQ-028 rdata and err SHALL hold their last values while rsp_valid=0.
REQ-029 req_valid while req_ready=0 SHALL be ignored; the requester must hold the request.

Reset
REQ-030 While rstn=0, the outputs SHALL be as follows: state=IDLE, counter=0, req_ready=1, rsp_valid=0, rdata=0, err=0.
REQ-031 Reset asserted mid-load SHALL discard the pending response: no rsp_valid after release.
REQ-032 Memory contents SHALL NOT be reset, and SHALL be retained across reset.

Verification
REQ-033 READ_LAT=1 word and byte paths:
- sw 0x8000_00FF to addr 0x10, next cycle lw 0x10 -> rsp_valid one cycle later, rdata=0x8000_00FF, err=0;
- lb 0x13 -> rdata=0xFFFF_FF80;
- lbu 0x13 -> rdata=0x0000_0080.
REQ-034 Halfword store merge: sh 0xBEEF to 0x22 over existing word 0x1111_1111 at 0x20 -> lw 0x20 returns 0xBEEF_1111; lh 0x22 returns 0xFFFF_BEEF; lhu returns 0x0000_BEEF.
REQ-035 Misalignment and illegal type:
- sw to 0x21 -> rsp_valid next cycle, err=1, rdata=0, word at 0x20 unchanged;
- req_type=011 -> err=1.
REQ-036 READ_LAT=3 handshake:
- load accepted at edge E0 -> req_ready=0 for 2 cycles;
- rsp_valid high only in the cycle after edge E0+2, with req_ready=1 that cycle;
- a second request held on req_valid throughout is accepted at that cycle's edge.
REQ-037 Address wrap: DEPTH=128, sw 0x1234_5678 to 0x204 -> lw 0x004 returns 0x1234_5678.
REQ-038 Reset mid-operation: READ_LAT=4, rstn pulsed low one cycle after load acceptance -> no rsp_valid for 6 cycles after release, req_ready=1, memory intact.
